// File: rtl/mul32_seq_ctrl_pkg.sv
// Shared types and sizes for the byte-serial 32x32 multiplier sequencer.
package mul32_seq_ctrl_pkg;

  localparam int BYTE_W = 8;
  localparam int OP_W   = 32;
  localparam int PROD_W = 64;
  localparam int STEPS  = 16;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DRAIN,
    DONE
  } state_t;

  // Left shift for the partial product of step k: 8 * (A byte index + B byte index).
  function automatic logic [5:0] step_shift(input logic [3:0] k);
    return {({1'b0, k[1:0]} + {1'b0, k[3:2]}), 3'b000};
  endfunction

endpackage

// File: rtl/mul32_seq_ctrl_mul8x8_unit.sv
// 8x8 unsigned multiplier with an optional output register (PIPE_MUL=1).
module mul8x8_unit #(
  parameter bit PIPE_MUL = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [15:0] p_comb;
  logic [15:0] p_reg;

  assign p_comb = {8'b0, a} * {8'b0, b};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_reg <= '0;
    end else begin
      p_reg <= p_comb;
    end
  end

  assign p = PIPE_MUL ? p_reg : p_comb;

endmodule

// File: rtl/mul32_seq_ctrl.sv
// Unsigned 32x32->64 multiply by walking all 16 byte pairs through one 8x8 multiplier.
module mul32_seq_ctrl
  import mul32_seq_ctrl_pkg::*;
#(
  parameter bit PIPE_MUL = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] i_msg_64,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] o_product_64,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  state_t              state_reg;
  logic [3:0]          k_reg;
  logic [OP_W-1:0]     a_reg;
  logic [OP_W-1:0]     b_reg;
  logic [PROD_W-1:0]   acc_reg;
  logic [PROD_W-1:0]   product_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;
  logic                busy_reg;

  logic [BYTE_W-1:0]   a_byte;
  logic [BYTE_W-1:0]   b_byte;
  logic [15:0]         pp;
  logic [3:0]          acc_k;
  logic [PROD_W-1:0]   acc_next;
  logic                last_step;

  assign a_byte = a_reg[{k_reg[1:0], 3'b000} +: BYTE_W];
  assign b_byte = b_reg[{k_reg[3:2], 3'b000} +: BYTE_W];

  mul8x8_unit #(.PIPE_MUL(PIPE_MUL)) u_mul (
    .clk  (clk),
    .rstn (rstn),
    .a    (a_byte),
    .b    (b_byte),
    .p    (pp)
  );

  // With a registered multiplier, pp belongs to the previous step; k wraps to 0 in DRAIN so k-1 = 15.
  assign acc_k     = PIPE_MUL ? (k_reg - 4'd1) : k_reg;
  assign acc_next  = acc_reg + ({{(PROD_W-16){1'b0}}, pp} << step_shift(acc_k));
  assign last_step = (k_reg == 4'(STEPS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      product_reg   <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= i_msg_64[31:0];
            b_reg        <= i_msg_64[63:32];
            k_reg        <= '0;
            acc_reg      <= '0;
            state_reg    <= MUL;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        MUL: begin
          k_reg <= k_reg + 4'd1;
          if (!PIPE_MUL || k_reg != 4'd0) begin
            acc_reg <= acc_next;
          end
          if (last_step) begin
            if (PIPE_MUL) begin
              state_reg <= DRAIN;
            end else begin
              state_reg     <= DONE;
              product_reg   <= acc_next;
              out_valid_reg <= 1'b1;
              busy_reg      <= 1'b0;
            end
          end
        end
        DRAIN: begin
          acc_reg       <= acc_next;
          product_reg   <= acc_next;
          state_reg     <= DONE;
          out_valid_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_reg;
  assign out_valid    = out_valid_reg;
  assign busy         = busy_reg;
  assign o_product_64 = product_reg;

endmodule
